walu_arbiter: RTL and testbench

- Shares one "walu" datapath instance (DATA_WIDTH operands) among N_REQ requesters.
- Arbitration is round-robin, one issue per cycle.
- Each issued operation is tagged with its requester index. The tag travels in a pipeline matched to the walu's fixed latency, and the result is steered back to the issuing requester.
- Sits between requester front-ends and the single walu instance in the walu subsystem.

---
 rtl/walu_arbiter.sv | 143 ++++++++++++++
 tb/tb_walu_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/walu_arbiter.sv
`timescale 1ns/1ps
// Round-robin front-end sharing one fixed-latency walu among N_REQ requesters.
// Each issue carries its requester id down a tag pipeline so the result is steered back.
module walu_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int ALU_LAT    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [N_REQ*OP_WIDTH-1:0]   req_op,
    output logic                        alu_valid,
    output logic [DATA_WIDTH-1:0]       alu_a,
    output logic [DATA_WIDTH-1:0]       alu_b,
    output logic [OP_WIDTH-1:0]         alu_op,
    input  logic [DATA_WIDTH-1:0]       alu_res,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_res,
    output logic                        busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [IDW-1:0]        r_ptr;
    logic                  r_alu_valid;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [OP_WIDTH-1:0]   r_alu_op;
    logic [IDW-1:0]        r_issue_id;
    logic [ALU_LAT-1:0]    r_tag_v;
    logic [IDW-1:0]        r_tag_id [ALU_LAT];
    logic [N_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_res;

    logic                  w_grant;
    logic [IDW-1:0]        w_winner;
    logic [IDW-1:0]        w_ptr_next;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [OP_WIDTH-1:0]   w_op;
    logic                  w_tag_v;
    logic [IDW-1:0]        w_tag_id;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_grant  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_grant && req_valid[(int'(r_ptr) + k) % N_REQ]) begin
                w_grant  = 1'b1;
                w_winner = IDW'((int'(r_ptr) + k) % N_REQ);
            end
        end
        // A grant during reset would be a handshake nobody captures.
        if (rst) begin
            w_grant = 1'b0;
        end
    end

    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                w_op = req_op[i*OP_WIDTH +: OP_WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_winner == IDW'(N_REQ - 1)) ? '0 : w_winner + IDW'(1);
    assign req_ready  = w_grant ? (ONE_HOT0 << w_winner) : '0;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_alu_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_issue_id  <= '0;
        end else begin
            r_alu_valid <= w_grant;
            if (w_grant) begin
                r_ptr      <= w_ptr_next;
                r_alu_a    <= w_a;
                r_alu_b    <= w_b;
                r_alu_op   <= w_op;
                r_issue_id <= w_winner;
            end
        end
    end

    // Tag stage k is valid in the cycle alu_valid+1+k; the last stage lines up with alu_res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_alu_valid;
            r_tag_id[0] <= r_issue_id;
            for (int k = 1; k < ALU_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    assign w_tag_v  = r_tag_v[ALU_LAT-1];
    assign w_tag_id = r_tag_id[ALU_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_res   <= '0;
        end else begin
            r_rsp_valid <= w_tag_v ? (ONE_HOT0 << w_tag_id) : '0;
            if (w_tag_v) begin
                r_rsp_res <= alu_res;
            end
        end
    end

    assign alu_valid = r_alu_valid;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_res   = r_rsp_res;
    assign busy      = r_alu_valid | (|r_tag_v) | (|r_rsp_valid);

endmodule

// File: tb/tb_walu_arbiter.sv
`timescale 1ns/1ps
// Directed bench for walu_arbiter with a two-cycle add/sub walu model.
module tb_walu_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 32;
    localparam int OW    = 4;
    localparam int LAT   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*DW-1:0]  req_a = '0;
    logic [N_REQ*DW-1:0]  req_b = '0;
    logic [N_REQ*OW-1:0]  req_op = '0;
    logic                 alu_valid;
    logic [DW-1:0]        alu_a;
    logic [DW-1:0]        alu_b;
    logic [OW-1:0]        alu_op;
    logic [DW-1:0]        alu_res;
    logic [N_REQ-1:0]     rsp_valid;
    logic [DW-1:0]        rsp_res;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    walu_arbiter #(
        .N_REQ(N_REQ), .DATA_WIDTH(DW), .OP_WIDTH(OW), .ALU_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_res(rsp_res), .busy(busy)
    );

    always #5 clk = ~clk;

    // walu model: op 0 = add, anything else = sub; result valid two cycles after alu_valid.
    logic [DW-1:0] m_s1 = '0;
    logic [DW-1:0] m_s2 = '0;
    always @(posedge clk) begin
        if (alu_valid) m_s1 <= (alu_op == '0) ? alu_a + alu_b : alu_a - alu_b;
        m_s2 <= m_s1;
    end
    assign alu_res = m_s2;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] op);
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
        req_op[i*OW +: OW] = op;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        step; step;
        rst = 1'b0;
        step;
        set_req(0, 32'd3, 32'd4, 4'd0);
        req_valid = 4'b0001;
        #3;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_pre_ready: got %b want %b", req_ready, 4'b0001); end
        step;
        #2;
        n_tests++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_alu_valid: got %b want 1", alu_valid); end
        rst = 1'b1;
        #1;
        n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid: got %b want 0", alu_valid); end
        n_tests++; if (alu_a !== 32'd0) begin n_fail++; $display("FAIL reset_alu_a: got %0d want 0", alu_a); end
        n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        req_valid = '0;
        step;
        rst = 1'b0;
    endtask

    task automatic test_single;
        step;
        set_req(2, 32'd5, 32'd7, 4'd0);
        req_valid = 4'b0100;
        #3;
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        step;
        req_valid = '0;
        #3;
        n_tests++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL single_alu_valid: got %b want 1", alu_valid); end
        n_tests++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 4'd0) begin n_fail++; $display("FAIL single_alu_ops: got a=%0d b=%0d op=%0d want 5 7 0", alu_a, alu_b, alu_op); end
        step;
        #3;
        n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL single_alu_idle: got %b want 0", alu_valid); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_inflight: got %b want 1", busy); end
        step;
        #3;
        n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_early: got %b want 0000", rsp_valid); end
        step;
        #3;
        n_tests++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
        n_tests++; if (rsp_res !== 32'd12) begin n_fail++; $display("FAIL single_rsp_res: got %0d want 12", rsp_res); end
        step;
        #3;
        n_tests++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_drain: got busy=%b rsp=%b want 0 0000", busy, rsp_valid); end
        n_tests++; if (rsp_res !== 32'd12) begin n_fail++; $display("FAIL single_rsp_hold: got %0d want 12", rsp_res); end
    endtask

    task automatic test_round_robin;
        logic [N_REQ-1:0] exp_v;
        logic [DW-1:0]    exp_r;
        int               id;
        rst = 1'b1;
        step;
        rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, DW'(100 * (i + 1)), DW'(i), 4'd0);
        for (int k = 0; k < 13; k++) begin
            step;
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #3;
            if (k < 8) begin
                exp_v = 4'b0001 << (k % 4);
                n_tests++; if (req_ready !== exp_v) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_v); end
            end
            if (k >= 4 && k < 12) begin
                id    = (k - 4) % 4;
                exp_v = 4'b0001 << id;
                exp_r = DW'(100 * (id + 1) + id);
                n_tests++; if (rsp_valid !== exp_v || rsp_res !== exp_r) begin n_fail++; $display("FAIL rr_rsp[%0d]: got %b/%0d want %b/%0d", k, rsp_valid, rsp_res, exp_v, exp_r); end
            end
            if (k == 12) begin
                n_tests++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rr_drain: got busy=%b rsp=%b want 0 0000", busy, rsp_valid); end
            end
        end
    endtask

    task automatic test_pointer_skip;
        set_req(0, 32'd1, 32'd1, 4'd0);
        set_req(3, 32'd50, 32'd5, 4'd0);
        step;
        req_valid = 4'b0001;
        #3;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_setup: got %b want 0001", req_ready); end
        step;
        req_valid = 4'b1001;
        #3;
        n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_first: got %b want 1000", req_ready); end
        step;
        #3;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_wrap: got %b want 0001", req_ready); end
        step;
        req_valid = '0;
        step;
        #3;
        n_tests++; if (rsp_valid !== 4'b0001 || rsp_res !== 32'd2) begin n_fail++; $display("FAIL skip_rsp0: got %b/%0d want 0001/2", rsp_valid, rsp_res); end
        step;
        #3;
        n_tests++; if (rsp_valid !== 4'b1000 || rsp_res !== 32'd55) begin n_fail++; $display("FAIL skip_rsp1: got %b/%0d want 1000/55", rsp_valid, rsp_res); end
        step;
        #3;
        n_tests++; if (rsp_valid !== 4'b0001 || rsp_res !== 32'd2) begin n_fail++; $display("FAIL skip_rsp2: got %b/%0d want 0001/2", rsp_valid, rsp_res); end
        step;
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_r;
        for (int k = 0; k < 9; k++) begin
            step;
            if (k < 3) begin
                set_req(1, DW'(k + 1), 32'd10, 4'd0);
                req_valid = 4'b0010;
            end else begin
                req_valid = 4'b0000;
            end
            #3;
            if (k < 3) begin
                n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b want 0010", k, req_ready); end
            end
            if (k >= 4 && k < 7) begin
                exp_r = DW'(11 + (k - 4));
                n_tests++; if (rsp_valid !== 4'b0010 || rsp_res !== exp_r) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %b/%0d want 0010/%0d", k, rsp_valid, rsp_res, exp_r); end
            end
            if (k == 7) begin
                n_tests++; if (rsp_valid !== 4'b0000 || rsp_res !== 32'd13) begin n_fail++; $display("FAIL b2b_gap: got %b/%0d want 0000/13", rsp_valid, rsp_res); end
            end
            if (k == 8) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", busy); end
            end
        end
    endtask

    task automatic test_reset_midflight;
        set_req(3, 32'd7, 32'd8, 4'd0);
        set_req(1, 32'd9, 32'd9, 4'd0);
        set_req(0, 32'd1, 32'd2, 4'd0);
        set_req(2, 32'd4, 32'd4, 4'd0);
        step;
        req_valid = 4'b1000;
        #3;
        n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_issue0: got %b want 1000", req_ready); end
        step;
        req_valid = 4'b0010;
        #3;
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_issue1: got %b want 0010", req_ready); end
        step;
        req_valid = '0;
        rst = 1'b1;
        #3;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        step;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step;
            #3;
            n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_ghost_rsp[%0d]: got %b want 0000", k, rsp_valid); end
        end
        step;
        req_valid = 4'b1111;
        #3;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_post_prio: got %b want 0001", req_ready); end
        step;
        req_valid = '0;
        step; step;
        step;
        #3;
        n_tests++; if (rsp_valid !== 4'b0001 || rsp_res !== 32'd3) begin n_fail++; $display("FAIL mid_post_rsp: got %b/%0d want 0001/3", rsp_valid, rsp_res); end
        step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_pointer_skip;
        test_back_to_back;
        test_reset_midflight;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
